adsr_envelope: RTL and testbench

Per-note amplitude envelope stage between the tone generator and the configurable filter. It runs an attack/decay/sustain/release state machine driven by a note gate, advancing once per audio sample strobe. Each incoming 32-bit signed tone sample is scaled by the current 16-bit envelope level. The top level drives `gate` with the OR of the one-hot note select, and `sample_tick` with the audio controller's write strobe.

---
 rtl/adsr_envelope.sv | 163 ++++++++++++++++
 tb/tb_adsr_envelope.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope.sv
// Per-note ADSR amplitude envelope: gate-driven state machine stepped on sample_tick, scaling each tone sample by the level.
// Optional exponential release is selected with `define ADSR_EXP_RELEASE_EN.
`timescale 1ns/1ps
module adsr_envelope #(
  parameter int DATA_WIDTH = 32,
  parameter int ENV_WIDTH  = 16
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  gate,
  input  logic                  sample_tick,
  input  logic [ENV_WIDTH-1:0]  attack_step,
  input  logic [ENV_WIDTH-1:0]  decay_step,
  input  logic [ENV_WIDTH-1:0]  sustain_level,
  input  logic [ENV_WIDTH-1:0]  release_step,
  input  logic [DATA_WIDTH-1:0] audio_in,
  output logic [DATA_WIDTH-1:0] audio_out,
  output logic                  out_valid,
  output logic [ENV_WIDTH-1:0]  env_level,
  output logic [2:0]            env_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic [ENV_WIDTH-1:0] LVL_FULL = {ENV_WIDTH{1'b1}};

  function automatic logic signed [DATA_WIDTH-1:0] f_scale(
    input logic signed [DATA_WIDTH-1:0] smp,
    input logic        [ENV_WIDTH-1:0]  lvl
  );
    logic signed [DATA_WIDTH+ENV_WIDTH:0] a;
    logic signed [DATA_WIDTH+ENV_WIDTH:0] b;
    logic signed [DATA_WIDTH+ENV_WIDTH:0] p;
    a = $signed({{(ENV_WIDTH+1){smp[DATA_WIDTH-1]}}, smp});
    b = $signed({{DATA_WIDTH{1'b0}}, 1'b0, lvl});
    p = a * b;
    return p[DATA_WIDTH+ENV_WIDTH-1:ENV_WIDTH];
  endfunction

  logic                  r_gate_meta;
  logic                  r_gate_sync;
  logic                  r_gate_prev;
  state_t                r_state;
  state_t                w_state_nxt;
  logic [ENV_WIDTH-1:0]  r_level;
  logic [ENV_WIDTH-1:0]  w_level_nxt;
  logic signed [DATA_WIDTH-1:0] r_audio_p1;
  logic                  r_vld_p1;

  logic                  w_rise;
  logic                  w_fall;
  logic [ENV_WIDTH:0]    w_att_sum;
  logic signed [ENV_WIDTH:0] w_dec_diff;
  logic                  w_dec_done;
  logic [ENV_WIDTH-1:0]  w_rel_amt;
  logic                  w_rel_done;

  // Gate synchronizer and edge-detect register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_gate_meta <= 1'b0;
      r_gate_sync <= 1'b0;
      r_gate_prev <= 1'b0;
    end else begin
      r_gate_meta <= gate;
      r_gate_sync <= r_gate_meta;
      r_gate_prev <= r_gate_sync;
    end
  end

  assign w_rise = r_gate_sync & ~r_gate_prev;
  assign w_fall = ~r_gate_sync & r_gate_prev;

  assign w_att_sum  = {1'b0, r_level} + {1'b0, attack_step};
  assign w_dec_diff = $signed({1'b0, r_level}) - $signed({1'b0, decay_step});
  assign w_dec_done = (decay_step == '0) || (w_dec_diff <= $signed({1'b0, sustain_level}));

`ifdef ADSR_EXP_RELEASE_EN
  // Proportional decrement; the +1 keeps it from stalling at small levels.
  assign w_rel_amt  = {4'b0000, r_level[ENV_WIDTH-1:4]} + ENV_WIDTH'(1);
  assign w_rel_done = (r_level <= w_rel_amt);
`else
  assign w_rel_amt  = release_step;
  assign w_rel_done = (release_step == '0) || (r_level <= release_step);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    if (w_rise) begin
      w_state_nxt = S_ATTACK;
    end else if (w_fall && (r_state == S_ATTACK || r_state == S_DECAY || r_state == S_SUSTAIN)) begin
      w_state_nxt = S_RELEASE;
    end else if (sample_tick) begin
      case (r_state)
        S_ATTACK: begin
          if ((attack_step == '0) || (w_att_sum >= {1'b0, LVL_FULL})) begin
            w_level_nxt = LVL_FULL;
            w_state_nxt = S_DECAY;
          end else begin
            w_level_nxt = w_att_sum[ENV_WIDTH-1:0];
          end
        end
        S_DECAY: begin
          if (w_dec_done) begin
            w_level_nxt = sustain_level;
            w_state_nxt = S_SUSTAIN;
          end else begin
            w_level_nxt = w_dec_diff[ENV_WIDTH-1:0];
          end
        end
        S_SUSTAIN: w_level_nxt = sustain_level;
        S_RELEASE: begin
          if (w_rel_done) begin
            w_level_nxt = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_level_nxt = r_level - w_rel_amt;
          end
        end
        default: begin
          w_level_nxt = '0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_level <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
    end
  end

  // Output stage: scale with the level held before this tick's update
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_audio_p1 <= '0;
      r_vld_p1   <= 1'b0;
    end else begin
      r_vld_p1 <= sample_tick;
      if (sample_tick) begin
        r_audio_p1 <= f_scale($signed(audio_in), r_level);
      end
    end
  end

  assign audio_out = r_audio_p1;
  assign out_valid = r_vld_p1;
  assign env_level = r_level;
  assign env_state = r_state;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed, table-driven bench for adsr_envelope; expectations follow the linear or exponential release build.
`timescale 1ns/1ps
module tb_adsr_envelope;

  localparam logic [2:0] S_IDLE = 3'd0, S_ATT = 3'd1, S_DEC = 3'd2, S_SUS = 3'd3, S_REL = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        gate;
  logic        tick;
  logic [15:0] att, dec, sus, rel;
  logic [31:0] ain;
  logic [31:0] aout;
  logic        vld;
  logic [15:0] lvl;
  logic [2:0]  st;

  int errors = 0;
  int checks = 0;

  adsr_envelope #(.DATA_WIDTH(32), .ENV_WIDTH(16)) dut (
    .CLOCK_50(clk), .reset(rst), .gate(gate), .sample_tick(tick),
    .attack_step(att), .decay_step(dec), .sustain_level(sus), .release_step(rel),
    .audio_in(ain), .audio_out(aout), .out_valid(vld), .env_level(lvl), .env_state(st)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic        g;
    logic [31:0] a_in;
    logic [2:0]  e_st;
    logic [15:0] e_lv;
    logic [31:0] e_out;
  } vec_t;

`ifdef ADSR_EXP_RELEASE_EN
  localparam int NV = 18;
  localparam logic [15:0] HOLD_LV = 16'h77FF;
`else
  localparam int NV = 19;
  localparam logic [15:0] HOLD_LV = 16'h4000;
`endif

  vec_t tv [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%h required 0x%h", nm, act, exp_v);
    end
  endtask

  task automatic set_gate(input logic v);
    @(negedge clk);
    gate = v;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic tick_chk(input string nm, input logic [2:0] e_st, input logic [15:0] e_lv,
                          input logic [31:0] e_out);
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    chk({nm, "_vld"}, {31'b0, vld}, 32'd1);
    chk({nm, "_state"}, {29'b0, st}, {29'b0, e_st});
    chk({nm, "_level"}, {16'b0, lvl}, {16'b0, e_lv});
    chk({nm, "_out"}, aout, e_out);
    @(posedge clk);
    #1;
    chk({nm, "_vld_low"}, {31'b0, vld}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] m, nx;
    int n;

    tv[0]  = '{1'b0, 32'h4000_0000, S_IDLE, 16'h0000, 32'h0000_0000};
    tv[1]  = '{1'b0, 32'h4000_0000, S_IDLE, 16'h0000, 32'h0000_0000};
    tv[2]  = '{1'b1, 32'h4000_0000, S_ATT,  16'h4000, 32'h0000_0000};
    tv[3]  = '{1'b1, 32'h4000_0000, S_ATT,  16'h8000, 32'h1000_0000};
    tv[4]  = '{1'b1, 32'h4000_0000, S_ATT,  16'hC000, 32'h2000_0000};
    tv[5]  = '{1'b1, 32'h4000_0000, S_DEC,  16'hFFFF, 32'h3000_0000};
    tv[6]  = '{1'b1, 32'h0001_0000, S_DEC,  16'hEFFF, 32'h0000_FFFF};
    tv[7]  = '{1'b1, 32'h0001_0000, S_DEC,  16'hDFFF, 32'h0000_EFFF};
    tv[8]  = '{1'b1, 32'h0001_0000, S_DEC,  16'hCFFF, 32'h0000_DFFF};
    tv[9]  = '{1'b1, 32'h0001_0000, S_DEC,  16'hBFFF, 32'h0000_CFFF};
    tv[10] = '{1'b1, 32'h0001_0000, S_DEC,  16'hAFFF, 32'h0000_BFFF};
    tv[11] = '{1'b1, 32'h0001_0000, S_DEC,  16'h9FFF, 32'h0000_AFFF};
    tv[12] = '{1'b1, 32'h0001_0000, S_DEC,  16'h8FFF, 32'h0000_9FFF};
    tv[13] = '{1'b1, 32'h0001_0000, S_SUS,  16'h8000, 32'h0000_8FFF};
    tv[14] = '{1'b1, 32'h4000_0000, S_SUS,  16'h8000, 32'h2000_0000};
    tv[15] = '{1'b1, 32'hC000_0000, S_SUS,  16'h8000, 32'hE000_0000};
    tv[16] = '{1'b1, 32'hFFFF_FFFF, S_SUS,  16'h8000, 32'hFFFF_FFFF};
`ifdef ADSR_EXP_RELEASE_EN
    tv[17] = '{1'b0, 32'h0001_0000, S_REL,  16'h77FF, 32'h0000_8000};
`else
    tv[17] = '{1'b0, 32'h0001_0000, S_REL,  16'h6000, 32'h0000_8000};
    tv[18] = '{1'b0, 32'h0001_0000, S_REL,  16'h4000, 32'h0000_6000};
`endif

    rst = 1'b1; gate = 1'b0; tick = 1'b0;
    att = 16'h4000; dec = 16'h1000; sus = 16'h8000; rel = 16'h2000;
    ain = 32'h4000_0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {29'b0, st}, {29'b0, S_IDLE});
    chk("rst_level", {16'b0, lvl}, 32'd0);
    chk("rst_out", aout, 32'd0);
    chk("rst_vld", {31'b0, vld}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (tv[i].g != gate) set_gate(tv[i].g);
      ain = tv[i].a_in;
      tick_chk($sformatf("vec%0d", i), tv[i].e_st, tv[i].e_lv, tv[i].e_out);
    end

    // Retrigger in RELEASE with the rise landing on a tick cycle
    ain = 32'h0001_0000;
    @(negedge clk);
    gate = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    chk("retrig_state", {29'b0, st}, {29'b0, S_ATT});
    chk("retrig_level", {16'b0, lvl}, {16'b0, HOLD_LV});
    chk("retrig_vld", {31'b0, vld}, 32'd1);
    chk("retrig_out", aout, {16'b0, HOLD_LV});
    tick_chk("retrig_next", S_ATT, HOLD_LV + 16'h4000, {16'b0, HOLD_LV});

    // Back-to-back ticks
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b1_vld", {31'b0, vld}, 32'd1);
    chk("b2b1_level", {16'b0, lvl}, {16'b0, HOLD_LV + 16'h8000});
    chk("b2b1_out", aout, {16'b0, HOLD_LV + 16'h4000});
    @(posedge clk);
    #1;
    tick = 1'b0;
    chk("b2b2_vld", {31'b0, vld}, 32'd1);
    chk("b2b2_state", {29'b0, st}, {29'b0, S_DEC});
    chk("b2b2_level", {16'b0, lvl}, 32'h0000_FFFF);
    chk("b2b2_out", aout, {16'b0, HOLD_LV + 16'h8000});

    // Full release from full scale down to IDLE
    set_gate(1'b0);
    chk("fall_state", {29'b0, st}, {29'b0, S_REL});
    chk("fall_level", {16'b0, lvl}, 32'h0000_FFFF);
    m = 16'hFFFF;
    n = 0;
    while (m != 16'h0 && n < 400) begin
`ifdef ADSR_EXP_RELEASE_EN
      nx = (m <= ((m >> 4) + 16'd1)) ? 16'h0 : m - ((m >> 4) + 16'd1);
`else
      nx = (m <= rel) ? 16'h0 : m - rel;
`endif
      tick_chk($sformatf("rel%0d", n), (nx == 16'h0) ? S_IDLE : S_REL, nx, {16'b0, m});
      m = nx;
      n++;
    end

    // Asynchronous reset in mid-envelope
    set_gate(1'b1);
    tick_chk("pre_rst_a", S_ATT, 16'h4000, 32'h0000_0000);
    tick_chk("pre_rst_b", S_ATT, 16'h8000, 32'h0000_4000);
    @(negedge clk);
    #3;
    rst = 1'b1;
    gate = 1'b0;
    #1;
    chk("mid_rst_state", {29'b0, st}, {29'b0, S_IDLE});
    chk("mid_rst_level", {16'b0, lvl}, 32'd0);
    chk("mid_rst_out", aout, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick_chk("post_rst", S_IDLE, 16'h0000, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
